seven_seg_decoder: RTL and testbench

SEVEN_SEG_DECODER -- requirements
Module: seven_seg_decoder

---
 rtl/seven_seg_decoder.sv | 152 +++++++++++++++
 tb/tb_seven_seg_decoder.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_decoder.sv
// seven_seg_decoder
//   Debounces an active-low seven-segment pattern, decodes it to a hex digit
//   and presents each new digit through a valid/ready output register.
//
// Parameters
//   STABLE_CYCLES  consecutive identical samples needed to accept a pattern (2..255)
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   seg_in[6:0]  active-low segment pattern, bit0=a .. bit6=g (already synchronised)
//   out_ready    consumer accepts the current digit
//   clr_overrun  synchronous clear of the overrun flag
//   digit_out    decoded hex value (0 when the pattern is illegal)
//   digit_err    accepted pattern is not a legal hex code
//   out_valid    digit_out / digit_err are valid
//   overrun      sticky: an event was dropped while the output was held
module seven_seg_decoder #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] seg_in,
  input  logic       out_ready,
  input  logic       clr_overrun,
  output logic [3:0] digit_out,
  output logic       digit_err,
  output logic       out_valid,
  output logic       overrun
);

  localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES - 1);
  localparam logic [6:0] BLANK   = 7'b1111111;

  typedef enum logic {SETTLE = 1'b0, LOCKED = 1'b1} state_t;

  state_t     state, state_nxt;
  logic [6:0] samp;
  logic [7:0] cnt, cnt_nxt;
  logic [6:0] last_pat;
  logic       last_vld;

  logic       same;
  logic       accept;
  logic       evt;
  logic       out_empty;
  logic       load;
  logic       drop;
  logic [4:0] dec;

  // Returns {illegal, digit}; illegal patterns decode to digit 0.
  function automatic logic [4:0] decode(input logic [6:0] p);
    logic [4:0] r;
    case (p)
      7'b1000000: r = {1'b0, 4'h0};
      7'b1111001: r = {1'b0, 4'h1};
      7'b0100100: r = {1'b0, 4'h2};
      7'b0110000: r = {1'b0, 4'h3};
      7'b0011001: r = {1'b0, 4'h4};
      7'b0010010: r = {1'b0, 4'h5};
      7'b0000010: r = {1'b0, 4'h6};
      7'b1111000: r = {1'b0, 4'h7};
      7'b0000000: r = {1'b0, 4'h8};
      7'b0010000: r = {1'b0, 4'h9};
      7'b0001000: r = {1'b0, 4'hA};
      7'b0000011: r = {1'b0, 4'hB};
      7'b1000110: r = {1'b0, 4'hC};
      7'b0100001: r = {1'b0, 4'hD};
      7'b0000110: r = {1'b0, 4'hE};
      7'b0001110: r = {1'b0, 4'hF};
      default:    r = {1'b1, 4'h0};
    endcase
    return r;
  endfunction

  // Stability counter and settle/locked state (next-state logic)
  always_comb begin
    same      = (seg_in == samp);
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    if (!same) begin
      cnt_nxt   = '0;
      state_nxt = SETTLE;
    end else begin
      if (cnt != CNT_MAX) cnt_nxt = cnt + 8'd1;
      if (state == SETTLE && cnt == CNT_MAX) begin
        accept    = 1'b1;
        state_nxt = LOCKED;
      end
    end
  end

  // Event classification: blank and repeats of the last reported pattern are silent.
  always_comb begin
    evt       = accept && (samp != BLANK) && !(last_vld && (last_pat == samp));
    out_empty = !out_valid || out_ready;
    load      = evt && out_empty;
    drop      = evt && !out_empty;
    dec       = decode(samp);
  end

  // Sampling / FSM register stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      samp  <= BLANK;
      cnt   <= '0;
      state <= SETTLE;
    end else begin
      samp  <= seg_in;
      cnt   <= cnt_nxt;
      state <= state_nxt;
    end
  end

  // Last-reported tracking (updates even when the event is dropped)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_pat <= BLANK;
      last_vld <= 1'b0;
    end else if (accept) begin
      if (samp == BLANK) begin
        last_vld <= 1'b0;
      end else if (evt) begin
        last_pat <= samp;
        last_vld <= 1'b1;
      end
    end
  end

  // Output register stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_out <= '0;
      digit_err <= 1'b0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (load) begin
        digit_out <= dec[3:0];
        digit_err <= dec[4];
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      // A drop in the same cycle wins over the clear.
      if (drop)             overrun <= 1'b1;
      else if (clr_overrun) overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_seven_seg_decoder.sv
// Directed testbench for seven_seg_decoder (STABLE_CYCLES = 4).
module tb_seven_seg_decoder;

  logic       clk;
  logic       rst_n;
  logic [6:0] seg_in;
  logic       out_ready;
  logic       clr_overrun;
  logic [3:0] digit_out;
  logic       digit_err;
  logic       out_valid;
  logic       overrun;

  int n_chk  = 0;
  int n_pass = 0;

  localparam logic [6:0] P0    = 7'b1000000;
  localparam logic [6:0] P1    = 7'b1111001;
  localparam logic [6:0] P2    = 7'b0100100;
  localparam logic [6:0] P3    = 7'b0110000;
  localparam logic [6:0] P4    = 7'b0011001;
  localparam logic [6:0] P5    = 7'b0010010;
  localparam logic [6:0] P7    = 7'b1111000;
  localparam logic [6:0] P8    = 7'b0000000;
  localparam logic [6:0] PBAD  = 7'b1010101;
  localparam logic [6:0] BLANK = 7'b1111111;

  seven_seg_decoder #(.STABLE_CYCLES(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .seg_in      (seg_in),
    .out_ready   (out_ready),
    .clr_overrun (clr_overrun),
    .digit_out   (digit_out),
    .digit_err   (digit_err),
    .out_valid   (out_valid),
    .overrun     (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  // Drive pattern at a falling edge, then observe `cycles` rising edges.
  // Index 1 is the first edge that samples the new pattern (E0).
  task automatic run_hold(input logic [6:0] p, input int cycles,
                          output int pulses, output int first_idx,
                          output logic [3:0] dig, output logic err);
    pulses    = 0;
    first_idx = 0;
    dig       = 4'hx;
    err       = 1'bx;
    @(negedge clk);
    seg_in = p;
    for (int i = 1; i <= cycles; i++) begin
      @(posedge clk);
      #1;
      if (out_valid === 1'b1) begin
        if (pulses == 0) begin
          first_idx = i;
          dig       = digit_out;
          err       = digit_err;
        end
        pulses++;
      end
    end
  endtask

  int         np, fi;
  logic [3:0] d;
  logic       e;

  initial begin
    rst_n       = 1'b0;
    seg_in      = BLANK;
    out_ready   = 1'b1;
    clr_overrun = 1'b0;
    #3;
    check("rst_valid",   out_valid, 0);
    check("rst_digit",   digit_out, 0);
    check("rst_err",     digit_err, 0);
    check("rst_overrun", overrun,   0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_hold(BLANK, 6, np, fi, d, e);
    check("blank_idle_pulses", np, 0);

    // Digit 2: single pulse at E0+4, no repeat while held.
    run_hold(P2, 10, np, fi, d, e);
    check("d2_pulses", np, 1);
    check("d2_latency", fi, 5);
    check("d2_digit", d, 2);
    check("d2_err", e, 0);

    // Short 4 then held 5.
    run_hold(P4, 3, np, fi, d, e);
    check("glitch4_pulses", np, 0);
    run_hold(P5, 8, np, fi, d, e);
    check("d5_pulses", np, 1);
    check("d5_latency", fi, 5);
    check("d5_digit", d, 5);

    // Illegal pattern.
    run_hold(PBAD, 8, np, fi, d, e);
    check("bad_pulses", np, 1);
    check("bad_digit", d, 0);
    check("bad_err", e, 1);

    // 3, blank, 3 -> two events.
    run_hold(P3, 8, np, fi, d, e);
    check("d3a_pulses", np, 1);
    check("d3a_digit", d, 3);
    run_hold(BLANK, 6, np, fi, d, e);
    check("blank_pulses", np, 0);
    run_hold(P3, 8, np, fi, d, e);
    check("d3b_pulses", np, 1);
    check("d3b_digit", d, 3);
    // 3 -> short glitch -> 3 again: no new event.
    run_hold(P8, 2, np, fi, d, e);
    check("glitch8_pulses", np, 0);
    run_hold(P3, 8, np, fi, d, e);
    check("d3_repeat_pulses", np, 0);

    // Held output, overrun, clear.
    @(negedge clk);
    out_ready = 1'b0;
    run_hold(P1, 8, np, fi, d, e);
    check("d1_latency", fi, 5);
    check("d1_hold_valid", out_valid, 1);
    check("d1_hold_digit", digit_out, 1);
    check("d1_no_overrun", overrun, 0);
    run_hold(P7, 8, np, fi, d, e);
    check("held_valid", out_valid, 1);
    check("held_digit", digit_out, 1);
    check("overrun_set", overrun, 1);
    @(negedge clk);
    clr_overrun = 1'b1;
    @(posedge clk); #1;
    check("overrun_clr", overrun, 0);
    check("clr_keeps_digit", digit_out, 1);
    @(negedge clk);
    clr_overrun = 1'b0;
    out_ready   = 1'b1;
    @(posedge clk); #1;
    check("xfer_drop_valid", out_valid, 0);
    // Last-reported was updated to 7 despite the drop.
    run_hold(BLANK, 2, np, fi, d, e);
    check("glitchb_pulses", np, 0);
    run_hold(P7, 8, np, fi, d, e);
    check("d7_suppressed", np, 0);

    // Asynchronous reset mid-handshake.
    @(negedge clk);
    out_ready = 1'b0;
    run_hold(P0, 8, np, fi, d, e);
    check("d0_hold_valid", out_valid, 1);
    #2;
    rst_n  = 1'b0;
    seg_in = BLANK;
    #1;
    check("async_rst_valid", out_valid, 0);
    check("async_rst_digit", digit_out, 0);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    run_hold(P0, 8, np, fi, d, e);
    check("d0_again_pulses", np, 1);
    check("d0_again_latency", fi, 5);
    check("d0_again_digit", d, 0);
    check("d0_again_err", e, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1);
  end

endmodule
